counter_compare: RTL and testbench

- Downstream stage of the up/down counter. Consumes the counter's value and carry pulse.
- Matches the counter value against a programmable compare register through an arm/match/ack state machine.
- Raises a sticky interrupt on a match and counts carry (wrap) events seen while armed.
- Sits between the counter and the interrupt/event fabric.

---
 rtl/counter_compare.sv | 100 ++++++++++
 tb/tb_counter_compare.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_compare.sv
// Compare stage behind the up/down counter: an arm/match/ack FSM with a sticky irq and a saturating wrap counter.
// Defining COUNTER_CMP_PWM_EN adds a registered PWM output (cnt_val < cmp_reg).
module counter_compare #(
  parameter int WIDTH     = 8,
  parameter int OVF_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     cnt_val,
  input  logic                 cnt_carry,
  input  logic [WIDTH-1:0]     cmp_val,
  input  logic                 cmp_wr,
  input  logic                 arm,
  input  logic                 irq_ack,
  output logic                 busy,
  output logic                 match,
  output logic                 irq,
  output logic [OVF_WIDTH-1:0] ovf_cnt,
  output logic                 ovf_sat,
  output logic                 pwm_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MATCHED = 2'd2
  } state_t;

  localparam logic [OVF_WIDTH-1:0] OVF_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] cmp_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmp_reg <= '0;
      busy    <= 1'b0;
      match   <= 1'b0;
      irq     <= 1'b0;
      ovf_cnt <= '0;
      ovf_sat <= 1'b0;
    end else begin
      // The compare below reads the old cmp_reg, so a write lands only after this edge.
      if (cmp_wr)
        cmp_reg <= cmp_val;
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state   <= ARMED;
            busy    <= 1'b1;
            ovf_cnt <= '0;
            ovf_sat <= 1'b0;
          end
        end
        ARMED: begin
          if (cnt_carry && (ovf_cnt != OVF_MAX)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
            ovf_sat <= (ovf_cnt == OVF_MAX - 1'b1);
          end
          if (cnt_val == cmp_reg) begin
            state <= MATCHED;
            match <= 1'b1;
            irq   <= 1'b1;
          end
        end
        MATCHED: begin
          if (irq_ack) begin
            irq <= 1'b0;
            if (arm) begin
              state   <= ARMED;
              ovf_cnt <= '0;
              ovf_sat <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNTER_CMP_PWM_EN
  always_ff @(posedge clk) begin
    if (rst)
      pwm_out <= 1'b0;
    else
      pwm_out <= (cnt_val < cmp_reg);
  end
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_counter_compare.sv
// Randomised and directed bench for counter_compare, checked against a rule-level reference model.
module tb_counter_compare;

  localparam int WIDTH     = 8;
  localparam int OVF_WIDTH = 4;
  localparam int OVF_MAX   = (1 << OVF_WIDTH) - 1;
  localparam int OUT_W     = OVF_WIDTH + 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WIDTH-1:0]     cnt_val;
  logic                 cnt_carry;
  logic [WIDTH-1:0]     cmp_val;
  logic                 cmp_wr;
  logic                 arm;
  logic                 irq_ack;
  logic                 busy;
  logic                 match;
  logic                 irq;
  logic [OVF_WIDTH-1:0] ovf_cnt;
  logic                 ovf_sat;
  logic                 pwm_out;

  int checks = 0;
  int errors = 0;

`ifdef COUNTER_CMP_PWM_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif

  // Reference model: mode 0 = idle, 1 = armed, 2 = matched; counts kept as plain ints.
  int m_mode;
  int m_cmp;
  int m_ovf;
  bit m_match;
  bit m_irq;
  bit m_pwm;

  counter_compare #(.WIDTH(WIDTH), .OVF_WIDTH(OVF_WIDTH)) dut (
    .clk(clk), .rst(rst), .cnt_val(cnt_val), .cnt_carry(cnt_carry),
    .cmp_val(cmp_val), .cmp_wr(cmp_wr), .arm(arm), .irq_ack(irq_ack),
    .busy(busy), .match(match), .irq(irq), .ovf_cnt(ovf_cnt),
    .ovf_sat(ovf_sat), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] dut_vec();
    return {busy, match, irq, ovf_cnt, ovf_sat, pwm_out};
  endfunction

  function automatic logic [OUT_W-1:0] model_vec();
    logic [OVF_WIDTH-1:0] o;
    o = OVF_WIDTH'(m_ovf);
    return {(m_mode != 0), m_match, m_irq, o, (m_ovf == OVF_MAX), m_pwm};
  endfunction

  task automatic model_edge();
    int cv;
    cv = int'(cnt_val);
    if (rst) begin
      m_mode = 0; m_cmp = 0; m_ovf = 0; m_match = 0; m_irq = 0; m_pwm = 0;
      return;
    end
    m_pwm   = PWM_EN && (cv < m_cmp);
    m_match = 0;
    if (m_mode == 0) begin
      if (arm) begin m_mode = 1; m_ovf = 0; end
    end else if (m_mode == 1) begin
      if (cnt_carry && m_ovf < OVF_MAX) m_ovf = m_ovf + 1;
      if (cv == m_cmp) begin m_mode = 2; m_match = 1; m_irq = 1; end
    end else begin
      if (irq_ack) begin
        m_irq = 0;
        if (arm) begin m_mode = 1; m_ovf = 0; end
        else m_mode = 0;
      end
    end
    if (cmp_wr) m_cmp = int'(cmp_val);
  endtask

  // Inputs are applied now, the model follows the edge, and sampling happens 1 time unit later.
  task automatic step(input bit r, input int cv, input bit cy, input int wv, input bit wr,
                      input bit ar, input bit ack);
    rst = r; cnt_val = WIDTH'(cv); cnt_carry = cy; cmp_val = WIDTH'(wv);
    cmp_wr = wr; arm = ar; irq_ack = ack;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; cnt_val = '0; cnt_carry = 0; cmp_val = '0; cmp_wr = 0; arm = 0; irq_ack = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, $urandom_range(0, 255), 1'($urandom), $urandom_range(0, 255),
           1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (dut_vec() !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %b expected %b", i, dut_vec(), {OUT_W{1'b0}});
      end
    end
  endtask

  task automatic test_match();
    int pulses = 0;
    step(0, 0, 0, 8'h05, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    for (int v = 0; v < 8; v++) begin
      step(0, v, 0, 0, 0, 0, 0);
      if (match === 1'b1) pulses++;
      checks++;
      if (match !== (v == 5) || irq !== (v >= 5) || dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL match_seq cnt=%0d: got match=%b irq=%b vec=%b expected match=%b irq=%b vec=%b",
                 v, match, irq, dut_vec(), (v == 5), (v >= 5), model_vec());
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL match_pulse_count: got %0d expected 1", pulses);
    end
    step(0, 7, 0, 0, 0, 0, 1);
    checks++;
    if (irq !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL match_ack: got irq=%b busy=%b expected irq=0 busy=0", irq, busy);
    end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    step(0, 0, 0, 8'h80, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 17; k++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      exp_cnt = (k < OVF_MAX) ? k : OVF_MAX;
      checks++;
      if (int'(ovf_cnt) != exp_cnt || ovf_sat !== (k >= OVF_MAX) || match !== 1'b0 ||
          dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL saturate pulse %0d: got cnt=%0d sat=%b match=%b expected cnt=%0d sat=%b match=0",
                 k, ovf_cnt, ovf_sat, match, exp_cnt, (k >= OVF_MAX));
      end
    end
    step(0, 8'h80, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, 8'h22, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 8'h22, 0, 0, 0, 0, 0);
    checks++;
    if (irq !== 1'b1 || int'(ovf_cnt) != 3) begin
      errors++;
      $display("[TB] FAIL b2b_setup: got irq=%b cnt=%0d expected irq=1 cnt=3", irq, ovf_cnt);
    end
    step(0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (busy !== 1'b1 || irq !== 1'b0 || ovf_cnt !== '0 || ovf_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_rearm: got busy=%b irq=%b cnt=%0d expected busy=1 irq=0 cnt=0",
               busy, irq, ovf_cnt);
    end
    step(0, 8'h22, 0, 0, 0, 0, 0);
    checks++;
    if (match !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_rematch: got match=%b expected 1", match);
    end
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 8'h33, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 8'h33, 1, 0, 0, 0, 0);
    checks++;
    if (match !== 1'b0 || irq !== 1'b0 || ovf_cnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got match=%b irq=%b cnt=%0d busy=%b expected all 0",
               match, irq, ovf_cnt, busy);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, (k == 0) ? 8'h33 : 0, 0, 0, 0, 0, 0);
      checks++;
      if (match !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mid_nomatch %0d: got match=%b busy=%b expected 0 0", k, match, busy);
      end
    end
  endtask

  task automatic test_pwm();
    int ones = 0;
    bit exp_pwm;
    step(0, 0, 0, 8'h40, 1, 0, 0);
    for (int v = 0; v < 256; v++) begin
      step(0, v, 0, 0, 0, 0, 0);
      exp_pwm = PWM_EN && (v < 64);
      if (pwm_out === 1'b1) ones++;
      if (v == 8'h3F || v == 8'h40 || v == 0) begin
        checks++;
        if (pwm_out !== exp_pwm) begin
          errors++;
          $display("[TB] FAIL pwm_edge cnt=%0d: got %b expected %b", v, pwm_out, exp_pwm);
        end
      end
    end
    checks++;
    if (ones != (PWM_EN ? 64 : 0)) begin
      errors++;
      $display("[TB] FAIL pwm_high_cycles: got %0d expected %0d", ones, PWM_EN ? 64 : 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 7), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 7), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    idle_inputs();
    m_mode = 0; m_cmp = 0; m_ovf = 0; m_match = 0; m_irq = 0; m_pwm = 0;
    #2;
    test_reset();
    test_match();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_pwm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
